// File: rtl/uart_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer_if
//   Bundles the UART receive strobe, the ALU operand/result bus, the UART
//   transmit handshake and the sequencer status pulses.
//
//   master : the sequencer side
//            in  rx_data[8], rx_valid, alu_result[8], alu_flags[4] {N,Z,C,V},
//                tx_busy
//            out alu_op[4], alu_a[8], alu_b[8], tx_data[8], tx_start,
//                busy, frame_err, overrun
//   slave  : the surrounding UART/ALU side (directions mirrored)
// ---------------------------------------------------------------------------
interface uart_alu_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic       tx_busy;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx_data, rx_valid, alu_result, alu_flags, tx_busy,
        output alu_op, alu_a, alu_b, tx_data, tx_start, busy, frame_err, overrun
    );

    modport slave (
        output rx_data, rx_valid, alu_result, alu_flags, tx_busy,
        input  alu_op, alu_a, alu_b, tx_data, tx_start, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer
//   Collects a 3-byte command (opcode, A, B) from the UART receiver, drives
//   the operands to the ALU, waits ALU_LATENCY cycles, captures result and
//   flags, then sends the result byte and the flag byte through the UART
//   transmitter's start/busy handshake.
//
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_alu_sequencer_if.master (rx strobe, ALU bus, tx handshake,
//           busy / frame_err / overrun status)
//
//   An opcode byte with a non-zero upper nibble, or a gap of TIMEOUT_CLKS
//   cycles between bytes of one frame, pulses frame_err. Bytes arriving
//   while a command is executing or being answered are dropped and pulse
//   overrun.
// ---------------------------------------------------------------------------
module uart_alu_sequencer #(
    parameter int ALU_LATENCY  = 2,
    parameter int TIMEOUT_CLKS = 43400
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_alu_sequencer_if.master bus
);
    // Counters only need to reach N-1.
    localparam int TO_W  = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int LAT_W = (ALU_LATENCY  > 1) ? $clog2(ALU_LATENCY)  : 1;

    typedef enum logic [2:0] {
        IDLE, GET_A, GET_B, EXEC, SEND_R, WAIT_R, SEND_F, WAIT_F
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [LAT_W-1:0]  lat_cnt_q;
    logic [3:0]        alu_op_q;
    logic [7:0]        alu_a_q, alu_b_q, result_q;
    logic [3:0]        flags_q;
    logic              frame_err_q, overrun_q, guard_q;

    logic ld_op, ld_a, ld_b, capture, bad_op, timeout, drop, tx_start;

    wire to_last  = (to_cnt_q  == TO_W'(TIMEOUT_CLKS - 1));
    wire lat_last = (lat_cnt_q == LAT_W'(ALU_LATENCY - 1));
    wire in_frame = (state_q == GET_A) || (state_q == GET_B);

    // Next-state and per-cycle strobes.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d  = state_q;
        ld_op    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        capture  = 1'b0;
        bad_op   = 1'b0;
        timeout  = 1'b0;
        drop     = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[7:4] == 4'h0) begin
                        ld_op   = 1'b1;
                        state_d = GET_A;
                    end else begin
                        bad_op  = 1'b1;
                    end
                end
            end
            // A byte in the last allowed cycle still wins over the timeout.
            GET_A: begin
                if (bus.rx_valid) begin
                    ld_a    = 1'b1;
                    state_d = GET_B;
                end else if (to_last) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            GET_B: begin
                if (bus.rx_valid) begin
                    ld_b    = 1'b1;
                    state_d = EXEC;
                end else if (to_last) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                drop = bus.rx_valid;
                if (lat_last) begin
                    capture = 1'b1;
                    state_d = SEND_R;
                end
            end
            SEND_R: begin
                drop = bus.rx_valid;
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = WAIT_R;
                end
            end
            // guard_q covers the cycle before the transmitter raises tx_busy.
            WAIT_R: begin
                drop = bus.rx_valid;
                if (!guard_q && !bus.tx_busy) state_d = SEND_F;
            end
            SEND_F: begin
                drop = bus.rx_valid;
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = WAIT_F;
                end
            end
            WAIT_F: begin
                drop = bus.rx_valid;
                if (!guard_q && !bus.tx_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q    <= '0;
            lat_cnt_q   <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            guard_q     <= 1'b0;
        end else begin
            // Cleared outside the frame states, so entry always starts at 0.
            if (bus.rx_valid || !in_frame) to_cnt_q <= '0;
            else                           to_cnt_q <= to_cnt_q + TO_W'(1);

            if (state_q == EXEC) lat_cnt_q <= lat_cnt_q + LAT_W'(1);
            else                 lat_cnt_q <= '0;

            if (ld_op) alu_op_q <= bus.rx_data[3:0];
            if (ld_a)  alu_a_q  <= bus.rx_data;
            if (ld_b)  alu_b_q  <= bus.rx_data;
            if (capture) begin
                result_q <= bus.alu_result;
                flags_q  <= bus.alu_flags;
            end

            frame_err_q <= bad_op || timeout;
            overrun_q   <= drop;
            guard_q     <= tx_start;
        end
    end

    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.tx_data   = ((state_q == SEND_F) || (state_q == WAIT_F))
                           ? {4'h0, flags_q} : result_q;
    assign bus.tx_start  = tx_start;
    assign bus.busy      = (state_q != IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_sequencer
//   Scoreboard bench: each issued frame pushes its two expected response
//   bytes (from an arithmetic ALU model) into a queue; a monitor pops one
//   entry per tx_start. Includes a one-stage ALU model and a transmitter
//   model that holds tx_busy for a random number of cycles.
// ---------------------------------------------------------------------------
module tb_uart_alu_sequencer;
    localparam int ALU_LATENCY  = 2;
    localparam int TIMEOUT_CLKS = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_alu_sequencer_if bus();
    logic tx_busy_m  = 1'b0;
    logic force_busy = 1'b0;
    assign bus.tx_busy = tx_busy_m | force_busy;

    uart_alu_sequencer #(
        .ALU_LATENCY (ALU_LATENCY),
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
    logic [7:0] exp_q[$];
    bit prev_start = 1'b0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ALU behaviour: returns {result, N, Z, C, V}.
    function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] w;
        logic       v;
        v = 1'b0;
        case (op)
            4'd0: w = {1'b0, a & b};
            4'd1: w = {1'b0, a | b};
            4'd2: begin
                w = {1'b0, a} + {1'b0, b};
                v = (a[7] == b[7]) && (w[7] != a[7]);
            end
            4'd3: begin
                w = {1'b0, a} - {1'b0, b};
                v = (a[7] != b[7]) && (w[7] != a[7]);
            end
            4'd4:    w = {1'b0, a ^ b};
            default: w = {1'b0, a} + {5'd0, op};
        endcase
        return {w[7:0], w[7], (w[7:0] == 8'd0), w[8], v};
    endfunction

    // ALU model with one register stage: output in cycle k+1 reflects
    // operands of cycle k.
    initial begin
        logic [11:0] nxt;
        bus.alu_result = 8'h00;
        bus.alu_flags  = 4'h0;
        forever begin
            @(negedge clk);
            nxt = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
            @(posedge clk);
            #1;
            {bus.alu_result, bus.alu_flags} = nxt;
        end
    end

    // Transmitter model: tx_busy rises the cycle after tx_start.
    initial begin
        int hold;
        forever begin
            @(negedge clk);
            if (rst_n && bus.tx_start) begin
                hold = $urandom_range(8, 1);
                @(posedge clk);
                #1 tx_busy_m = 1'b1;
                repeat (hold) @(posedge clk);
                #1 tx_busy_m = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every tx_start, counts status pulses.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_start = 1'b0;
            end else begin
                if (bus.tx_start) begin
                    check(!prev_start, "tx_start_width", {31'd0, prev_start}, 0);
                    check(!bus.tx_busy, "tx_start_while_busy", {31'd0, bus.tx_busy}, 0);
                    check(exp_q.size() != 0, "unexpected_tx_start", {24'd0, bus.tx_data}, 0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(bus.tx_data == e, "tx_data", {24'd0, bus.tx_data}, {24'd0, e});
                    end
                end
                if (bus.frame_err) fe_cnt++;
                if (bus.overrun)   ov_cnt++;
                prev_start = bus.tx_start;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic push_expected(input logic [3:0] op, input logic [7:0] a,
                                 input logic [7:0] b);
        logic [11:0] r;
        r = alu_fn(op, a, b);
        exp_q.push_back(r[11:4]);
        exp_q.push_back({4'h0, r[3:0]});
    endtask

    task automatic send_frame(input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input int gap,
                              input bit lat_chk, input bit inj_exec);
        int n;
        push_expected(op, a, b);
        send_byte({4'h0, op});
        idle_cycles(gap);
        send_byte(a);
        idle_cycles(gap);
        send_byte(b);
        if (inj_exec) begin
            send_byte(8'hFF);
            exp_ov++;
        end else if (lat_chk) begin
            n = 1;
            @(negedge clk);
            while (!bus.tx_start && n < 100) begin
                @(negedge clk);
                n++;
            end
            check(n == ALU_LATENCY + 1, "latency", n, ALU_LATENCY + 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((bus.busy || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(n < 3000, {name, "_idle_bound"}, n, 3000);
        repeat (2) @(negedge clk);
        check(fe_cnt == exp_fe, {name, "_frame_err_count"}, fe_cnt, exp_fe);
        check(ov_cnt == exp_ov, {name, "_overrun_count"}, ov_cnt, exp_ov);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.tx_start && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(bus.tx_start == 1'b1, {name, "_start_seen"}, {31'd0, bus.tx_start}, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string name);
        check(bus.busy == 1'b0,      {name, "_busy"},      {31'd0, bus.busy}, 0);
        check(bus.tx_start == 1'b0,  {name, "_tx_start"},  {31'd0, bus.tx_start}, 0);
        check(bus.frame_err == 1'b0, {name, "_frame_err"}, {31'd0, bus.frame_err}, 0);
        check(bus.overrun == 1'b0,   {name, "_overrun"},   {31'd0, bus.overrun}, 0);
        check(bus.alu_op == 4'h0,    {name, "_alu_op"},    {28'd0, bus.alu_op}, 0);
        check(bus.alu_a == 8'h00,    {name, "_alu_a"},     {24'd0, bus.alu_a}, 0);
        check(bus.alu_b == 8'h00,    {name, "_alu_b"},     {24'd0, bus.alu_b}, 0);
        check(bus.tx_data == 8'h00,  {name, "_tx_data"},   {24'd0, bus.tx_data}, 0);
    endtask

    initial begin
        int n;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;
        idle_cycles(2);

        // Basic frame: 5 + 3 = 8, flags 0.
        send_frame(4'h2, 8'h05, 8'h03, 0, 1'b1, 1'b0);
        wait_idle("basic");

        // Bad opcode, then a normal frame.
        send_byte(8'h82);
        @(negedge clk);
        check(bus.frame_err == 1'b1, "bad_op_pulse", {31'd0, bus.frame_err}, 1);
        check(bus.busy == 1'b0, "bad_op_busy", {31'd0, bus.busy}, 0);
        exp_fe++;
        @(posedge clk);
        #1;
        @(negedge clk);
        check(bus.frame_err == 1'b0, "bad_op_single", {31'd0, bus.frame_err}, 0);
        @(posedge clk);
        #1;
        send_frame(4'h3, 8'h10, 8'h20, 1, 1'b1, 1'b0);
        wait_idle("after_bad_op");

        // Timeout after operand A, then a byte in the last allowed cycle.
        send_byte(8'h01);
        send_byte(8'h10);
        idle_cycles(TIMEOUT_CLKS - 1);
        @(negedge clk);
        check(bus.busy == 1'b1, "pre_timeout_busy", {31'd0, bus.busy}, 1);
        check(bus.frame_err == 1'b0, "pre_timeout_frame_err", {31'd0, bus.frame_err}, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check(bus.busy == 1'b0, "timeout_busy", {31'd0, bus.busy}, 0);
        check(bus.frame_err == 1'b1, "timeout_frame_err", {31'd0, bus.frame_err}, 1);
        check(bus.alu_op == 4'h1, "timeout_keeps_op", {28'd0, bus.alu_op}, 1);
        check(bus.alu_a == 8'h10, "timeout_keeps_a", {24'd0, bus.alu_a}, 8'h10);
        exp_fe++;
        @(posedge clk);
        #1;
        wait_idle("timeout");
        push_expected(4'h1, 8'h22, 8'h5A);
        send_byte(8'h01);
        send_byte(8'h22);
        idle_cycles(TIMEOUT_CLKS - 1);
        send_byte(8'h5A);
        wait_idle("timeout_edge");

        // Transmitter held busy for 50 cycles after entering SEND_R.
        force_busy = 1'b1;
        send_frame(4'h4, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
        idle_cycles(ALU_LATENCY + 50);
        check(exp_q.size() == 2, "busy_hold_no_start", exp_q.size(), 2);
        force_busy = 1'b0;
        @(negedge clk);
        check(bus.tx_start == 1'b1, "start_after_busy", {31'd0, bus.tx_start}, 1);
        @(posedge clk);
        #1;
        wait_idle("busy_hold");

        // Overrun during EXEC and during WAIT_R.
        send_frame(4'h2, 8'h7F, 8'h01, 0, 1'b0, 1'b1);
        wait_start("ovr_result");
        send_byte(8'hFF);
        exp_ov++;
        wait_idle("overrun");

        // Back-to-back: opcode in the first IDLE cycle after WAIT_F.
        send_frame(4'h0, 8'hF0, 8'h3C, 0, 1'b0, 1'b0);
        push_expected(4'h3, 8'h50, 8'h60);
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(n < 500, "b2b_idle_bound", n, 500);
        bus.rx_data  = 8'h03;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
        send_byte(8'h50);
        send_byte(8'h60);
        wait_idle("b2b");

        // Reset during GET_B.
        send_byte(8'h03);
        send_byte(8'h44);
        #2 rst_n = 1'b0;
        #1 check_zero("rst_get_b");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(30);
        wait_idle("rst_get_b_after");

        // Reset during WAIT_F.
        send_frame(4'h1, 8'h0F, 8'hC0, 0, 1'b0, 1'b0);
        wait_start("rst_wf_r");
        wait_start("rst_wf_f");
        #2 rst_n = 1'b0;
        #1 check_zero("rst_wait_f");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_cycles(30);
        wait_idle("rst_wait_f_after");
        send_frame(4'h2, 8'h80, 8'h80, 0, 1'b1, 1'b0);
        wait_idle("post_reset_frame");

        // Randomized traffic.
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(9, 0);
            if (r == 0) begin
                send_byte({4'($urandom_range(15, 1)), 4'($urandom)});
                exp_fe++;
                wait_idle("rand_bad_op");
            end else begin
                send_frame(4'($urandom), 8'($urandom), 8'($urandom),
                           $urandom_range(5, 0), r != 1, r == 1);
                wait_idle("rand_frame");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Command sequencer between the UART receive path and the ALU.
- Assembles a 3-byte command frame (opcode, operand A, operand B) from received bytes, presents the operands to the ALU, waits a fixed latency and captures result and flags.
- Returns two response bytes (result, then flags) through the UART transmitter's start/busy handshake.
- Enforces an inter-byte timeout and reports framing and overrun errors.

Parameters:
- ALU_LATENCY, 2, cycles from operands stable to alu_result/alu_flags valid (≥1).
- TIMEOUT_CLKS, 43400, max clk cycles between bytes inside one frame (~10 byte times at 434 clks/bit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte, valid only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte.
- alu_result  in  8  ALU result.
- alu_flags  in  4  ALU flags {N,Z,C,V}.
- tx_busy  in  1  transmitter busy; rises no later than the cycle after tx_start.
- alu_op  out  4  opcode to ALU.
- alu_a  out  8  operand A.
- alu_b  out  8  operand B.
- tx_data  out  8  byte to transmit; held stable while tx_start=1.
- tx_start  out  1  one-cycle transmit request.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse: bad opcode or timeout.
- overrun  out  1  one-cycle pulse: byte dropped during EXEC/SEND.

Behaviour:
- Reset is async on rst_n=0.
  - State = IDLE.
  - alu_op, alu_a, alu_b, tx_data = 0.
  - tx_start, busy, frame_err, overrun = 0.
  - Timeout and latency counters = 0.
- State register is 3 bits. States: IDLE, GET_A, GET_B, EXEC, SEND_R, WAIT_R, SEND_F, WAIT_F.
- IDLE, on rx_valid:
  - If rx_data[7:4]==0: latch alu_op=rx_data[3:0] and go to GET_A.
  - Otherwise: pulse frame_err next cycle and stay in IDLE.
- GET_A: on rx_valid, latch alu_a and go to GET_B.
- GET_B: on rx_valid, latch alu_b and go to EXEC.
- Timeout in GET_A/GET_B:
  - The counter clears on entry and on every rx_valid, and increments otherwise.
  - When the counter reaches TIMEOUT_CLKS-1 with no rx_valid: go to IDLE and pulse frame_err.
  - alu_op/alu_a/alu_b keep their old values.
  - rx_valid in that same cycle wins: the byte is accepted and there is no timeout.
- EXEC:
  - The latency counter clears on entry and counts ALU_LATENCY cycles.
  - In the last cycle, capture alu_result into the result register and {4'b0,alu_flags} into the flag register, then go to SEND_R.
  - alu_op/a/b stay stable throughout EXEC.
- SEND_R:
  - When tx_busy=0: drive tx_data=result, tx_start=1 for exactly one cycle, then go to WAIT_R.
  - While tx_busy=1: wait, with tx_start=0.
- WAIT_R:
  - The first cycle is a guard cycle; tx_busy is ignored.
  - Afterwards, go to SEND_F when tx_busy=0.
- SEND_F / WAIT_F: same as SEND_R / WAIT_R, with tx_data=flag byte. WAIT_F exits to IDLE.
- rx_valid in EXEC, SEND_R, WAIT_R, SEND_F or WAIT_F:
  - The byte is discarded.
  - overrun pulses the following cycle.
  - State and registers are unaffected.
- busy is combinational: (state != IDLE).
- frame_err and overrun are registered and last exactly one cycle per event.
- Back-to-back frames: an rx_valid arriving in the first IDLE cycle after WAIT_F is accepted as a new opcode.
- Latency, last rx_valid (operand B) to first tx_start: ALU_LATENCY+1 cycles when tx_busy=0.
- Reset mid-frame or mid-transmit aborts immediately. No tx_start is issued after rst_n deasserts until a full new frame is received.

Test Plan:
1. rx bytes 0x02, 0x05, 0x03, with the ALU model returning 0x08 and flags 0x0, tx_busy idle → tx_start pulses with tx_data=0x08, then 0x00; busy falls after WAIT_F; no error pulses.
2. Opcode byte 0x82 in IDLE → frame_err pulses once, state stays IDLE, busy=0; a following valid frame completes normally.
3. Send 0x01 and 0x10, then silence for TIMEOUT_CLKS cycles → frame_err pulses once, state returns to IDLE; a byte arriving on cycle TIMEOUT_CLKS-1 instead is accepted as operand B.
4. Hold tx_busy=1 for 50 cycles on entry to SEND_R → no tx_start until tx_busy=0, then a single-cycle tx_start with tx_data stable.
5. Inject rx_valid=1 (data 0xFF) during EXEC and during WAIT_R → overrun pulses each time; transmitted bytes are unchanged (result, flags).
6. Assert rst_n=0 during GET_B and during WAIT_F → all outputs 0 asynchronously; after release there is no tx_start until a full new frame arrives.
